// File: rtl/alu_issue_ctrl_if.sv
// Handshake/bus bundle between the ALU issue sequencer and its environment.
// Carries the start/busy/done control, program ROM port, ALU operand/result
// port and data-memory request/ack port; master = sequencer, slave = peers.
interface alu_issue_ctrl_if #(
  parameter int AW = 8
);
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] instr_addr;
  logic [15:0]   instr_data;
  logic [15:0]   alu_a;
  logic [15:0]   alu_b;
  logic [3:0]    alu_sel;
  logic [15:0]   alu_result;
  logic          alu_zflag;
  logic          mem_req;
  logic          mem_we;
  logic [7:0]    mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    input  start, instr_data, alu_result, alu_zflag, mem_rdata, mem_ack,
    output busy, done, instr_addr, alu_a, alu_b, alu_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, instr_data, alu_result, alu_zflag, mem_rdata, mem_ack,
    input  busy, done, instr_addr, alu_a, alu_b, alu_sel,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Sequencer fetching 16-bit instructions and driving an external combinational ALU.
// Ports: clk, rst (async active-low), bus (master modport: start/busy/done,
// ROM address/data, registered ALU operands + result/zflag, data-memory req/ack).
module alu_issue_ctrl #(
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.master  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;

  localparam logic [3:0] OP_LOAD   = 4'b0011;
  localparam logic [3:0] OP_STORE  = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1111;
  localparam logic [3:0] SEL_RST   = 4'b1101;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          zreg_q, zreg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    rd_q, rd_d;
  logic [15:0]   alu_a_q, alu_a_d;
  logic [15:0]   alu_b_q, alu_b_d;
  logic [3:0]    alu_sel_q, alu_sel_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [15:0]   rf_q [0:7];

  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [15:0]   rf_wdata;

  logic [3:0]    op;
  logic [15:0]   ra_val, rb_val;
  logic [AW-1:0] pc_inc, br_target;

  function automatic logic is_alu_op(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b0111,
      4'b1000, 4'b1001, 4'b1010, 4'b1100: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign op     = bus.instr_data[15:12];
  assign ra_val = rf_q[bus.instr_data[8:6]];
  assign rb_val = rf_q[bus.instr_data[5:3]];
  assign pc_inc = pc_q + {{(AW-1){1'b0}}, 1'b1};

  // Branch target is the low byte of the instruction, zero-extended to AW.
  always_comb begin
    br_target      = '0;
    br_target[7:0] = bus.instr_data[7:0];
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    zreg_d      = zreg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_d        = rd_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we       = 1'b0;
    rf_waddr    = rd_q;
    rf_wdata    = bus.alu_result;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          zreg_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      // ROM is synchronous: instr_addr is already PC, data arrives next cycle.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        rd_d = bus.instr_data[11:9];
        if (is_alu_op(op)) begin
          alu_a_d   = ra_val;
          alu_b_d   = rb_val;
          alu_sel_d = op;
          state_d   = S_EXEC;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: begin
              mem_req_d   = 1'b1;
              mem_we_d    = (op == OP_STORE);
              mem_addr_d  = ra_val[7:0];
              if (op == OP_STORE) mem_wdata_d = rb_val;
              state_d     = S_MEM;
            end
            OP_BRANCH: begin
              pc_d    = zreg_q ? br_target : pc_inc;
              state_d = S_FETCH;
            end
            OP_HALT: begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
            default: begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_EXEC: begin
        rf_we   = 1'b1;
        zreg_d  = bus.alu_zflag;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_MEM: begin
        // All mem_* registers stay untouched until the ack arrives.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          rf_we     = !mem_we_q;
          rf_wdata  = bus.mem_rdata;
          pc_d      = pc_inc;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      zreg_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= SEL_RST;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      zreg_q      <= zreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_q        <= rd_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.instr_addr = pc_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: ROM, ALU and data-memory peers modelled here.
module tb_alu_issue_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_issue_ctrl_if #(.AW(8)) bus ();

  alu_issue_ctrl #(.AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM, synchronous read.
  logic [15:0] rom [0:255];
  always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

  // Combinational ALU peer.
  always_comb begin
    case (bus.alu_sel)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_a - bus.alu_b;
      4'b0010: bus.alu_result = bus.alu_a * bus.alu_b;
      4'b0101: bus.alu_result = bus.alu_a * bus.alu_b + bus.alu_a;
      4'b0111: bus.alu_result = bus.alu_a & bus.alu_b;
      4'b1000: bus.alu_result = bus.alu_a | bus.alu_b;
      4'b1001: bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'b1010: bus.alu_result = ~(bus.alu_a ^ bus.alu_b);
      4'b1100: bus.alu_result = {15'b0, bus.alu_a == bus.alu_b};
      default: bus.alu_result = 16'h0000;
    endcase
    bus.alu_zflag = (bus.alu_result == 16'h0000);
  end

  // Data memory: ack after load_wait/store_wait idle MEM cycles.
  logic [15:0] dmem [0:255];
  int          load_wait;
  int          store_wait;
  int          mem_cnt;
  logic [7:0]  st_addr;
  logic [15:0] st_data;
  always @(negedge clk) begin
    if (!rst) begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'h0000;
      mem_cnt       = 0;
      st_addr       = 8'h00;
      st_data       = 16'h0000;
    end else if (bus.mem_ack) begin
      bus.mem_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (mem_cnt >= (bus.mem_we ? store_wait : load_wait)) begin
        bus.mem_ack = 1'b1;
        mem_cnt     = 0;
        if (bus.mem_we) begin
          st_addr = bus.mem_addr;
          st_data = bus.mem_wdata;
        end else begin
          bus.mem_rdata = dmem[bus.mem_addr];
        end
      end else begin
        mem_cnt++;
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb);
    return {op, rd, ra, rb, 3'b000};
  endfunction

  function automatic logic [15:0] br(input logic [7:0] tgt);
    return {4'hB, 4'h0, tgt};
  endfunction

  // Per-cycle trace captured #1 after each rising edge of a run.
  logic [7:0]  tr_pc   [0:127];
  logic [3:0]  tr_sel  [0:127];
  logic [15:0] tr_a    [0:127];
  logic [15:0] tr_b    [0:127];
  logic [15:0] tr_wd   [0:127];
  logic [7:0]  tr_addr [0:127];
  logic        tr_req  [0:127];
  logic        tr_we   [0:127];
  logic        tr_busy [0:127];
  int          ncyc;
  int          done_cyc;

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
  endtask

  // Pulse start, then trace until done (or budget). Cycle 0 = first FETCH.
  task automatic run_prog(input int budget, input int pulse_at);
    done_cyc = -1;
    ncyc     = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < budget && c < 128; c++) begin
      tr_pc[c]   = bus.instr_addr;
      tr_sel[c]  = bus.alu_sel;
      tr_a[c]    = bus.alu_a;
      tr_b[c]    = bus.alu_b;
      tr_wd[c]   = bus.mem_wdata;
      tr_addr[c] = bus.mem_addr;
      tr_req[c]  = bus.mem_req;
      tr_we[c]   = bus.mem_we;
      tr_busy[c] = bus.busy;
      ncyc       = c + 1;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      bus.start = (c == pulse_at);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
  endtask

  function automatic int first_seen(input logic [7:0] pc);
    for (int i = 0; i < ncyc; i++) if (tr_pc[i] == pc) return i;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", bus.mem_req); end
    total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", bus.mem_we); end
    total++; if (bus.alu_a !== 16'h0) begin bad++; $display("FAIL rst_alu_a got=%h want=0000", bus.alu_a); end
    total++; if (bus.alu_b !== 16'h0) begin bad++; $display("FAIL rst_alu_b got=%h want=0000", bus.alu_b); end
    total++; if (bus.alu_sel !== 4'hD) begin bad++; $display("FAIL rst_alu_sel got=%h want=d", bus.alu_sel); end
    total++; if (bus.mem_addr !== 8'h0) begin bad++; $display("FAIL rst_mem_addr got=%h want=00", bus.mem_addr); end
    total++; if (bus.mem_wdata !== 16'h0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0000", bus.mem_wdata); end
    total++; if (bus.instr_addr !== 8'h0) begin bad++; $display("FAIL rst_instr_addr got=%h want=00", bus.instr_addr); end
  endtask

  // Two loads, three ALU ops, address build, store, halt at 7; start pulsed mid-run.
  task automatic test_alu_ops();
    int exp_cyc [0:7];
    exp_cyc = '{0, 3, 6, 9, 12, 15, 18, 21};
    clear_rom();
    dmem[8'h00] = 16'h0005;
    dmem[8'h05] = 16'h0003;
    load_wait  = 0;
    store_wait = 0;
    rom[0] = enc(4'b0011, 3'd1, 3'd0, 3'd0);  // R1 <= mem[R0]
    rom[1] = enc(4'b0011, 3'd2, 3'd1, 3'd0);  // R2 <= mem[R1]
    rom[2] = enc(4'b0000, 3'd3, 3'd1, 3'd2);  // add
    rom[3] = enc(4'b0001, 3'd4, 3'd1, 3'd2);  // sub
    rom[4] = enc(4'b0010, 3'd5, 3'd1, 3'd2);  // mul
    rom[5] = enc(4'b0000, 3'd7, 3'd3, 3'd3);  // R7 = R3 + R3 = 0x10
    rom[6] = enc(4'b0100, 3'd0, 3'd7, 3'd2);  // mem[R7] <= R2
    rom[7] = 16'hF000;
    run_prog(60, 10);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (first_seen(8'(k)) !== exp_cyc[k]) begin
        bad++; $display("FAIL pc%0d_first_cycle got=%0d want=%0d", k, first_seen(8'(k)), exp_cyc[k]);
      end
    end
    total++; if (done_cyc !== 23) begin bad++; $display("FAIL halt_done_cycle got=%0d want=23", done_cyc); end
    total++; if (tr_busy[0] !== 1'b1) begin bad++; $display("FAIL busy_rise got=%b want=1", tr_busy[0]); end
    total++; if (tr_busy[22] !== 1'b1) begin bad++; $display("FAIL busy_before_halt got=%b want=1", tr_busy[22]); end
    total++; if (tr_busy[23] !== 1'b0) begin bad++; $display("FAIL busy_fall_with_done got=%b want=0", tr_busy[23]); end
    total++; if (tr_req[2] !== 1'b1 || tr_we[2] !== 1'b0) begin bad++; $display("FAIL load_req got=%b/%b want=1/0", tr_req[2], tr_we[2]); end
    total++; if (tr_addr[5] !== 8'h05) begin bad++; $display("FAIL load2_addr got=%h want=05", tr_addr[5]); end
    total++; if (tr_sel[7] !== 4'hD) begin bad++; $display("FAIL sel_before_first_exec got=%h want=d", tr_sel[7]); end
    total++; if (tr_sel[8] !== 4'h0 || tr_a[8] !== 16'h5 || tr_b[8] !== 16'h3) begin
      bad++; $display("FAIL add_issue got=%h/%h/%h want=0/0005/0003", tr_sel[8], tr_a[8], tr_b[8]); end
    total++; if (tr_sel[9] !== 4'h0) begin bad++; $display("FAIL sel_hold got=%h want=0", tr_sel[9]); end
    total++; if (tr_sel[11] !== 4'h1) begin bad++; $display("FAIL sub_sel got=%h want=1", tr_sel[11]); end
    total++; if (tr_sel[14] !== 4'h2) begin bad++; $display("FAIL mul_sel got=%h want=2", tr_sel[14]); end
    total++; if (tr_a[17] !== 16'h8 || tr_b[17] !== 16'h8) begin
      bad++; $display("FAIL r3_writeback got=%h/%h want=0008/0008", tr_a[17], tr_b[17]); end
    total++; if (tr_addr[20] !== 8'h10 || tr_wd[20] !== 16'h3) begin
      bad++; $display("FAIL store_fields got=%h/%h want=10/0003", tr_addr[20], tr_wd[20]); end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", bus.done); end
  endtask

  // Restart with registers kept: store R2 to R7 with ack delayed 4 cycles.
  task automatic test_mem_handshake();
    clear_rom();
    store_wait = 4;
    rom[0] = enc(4'b0100, 3'd0, 3'd7, 3'd2);
    rom[1] = 16'hF000;
    run_prog(40, -1);
    for (int c = 2; c <= 5; c++) begin
      total++;
      if (tr_req[c] !== 1'b1 || tr_we[c] !== 1'b1 || tr_addr[c] !== 8'h10 || tr_wd[c] !== 16'h0003) begin
        bad++; $display("FAIL store_hold_c%0d got=%b/%b/%h/%h want=1/1/10/0003", c, tr_req[c], tr_we[c], tr_addr[c], tr_wd[c]);
      end
    end
    total++; if (tr_req[6] !== 1'b1) begin bad++; $display("FAIL store_ack_cycle_req got=%b want=1", tr_req[6]); end
    total++; if (tr_req[7] !== 1'b0) begin bad++; $display("FAIL store_req_drop got=%b want=0", tr_req[7]); end
    total++; if (first_seen(8'h01) !== 7) begin bad++; $display("FAIL store_next_fetch got=%0d want=7", first_seen(8'h01)); end
    total++; if (st_addr !== 8'h10 || st_data !== 16'h0003) begin
      bad++; $display("FAIL store_written got=%h/%h want=10/0003", st_addr, st_data); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL store_prog_done got=%0d want=9", done_cyc); end
    store_wait = 0;
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0]     = enc(4'b1001, 3'd6, 3'd3, 3'd4);  // xor R3,R4
    rom[1]     = enc(4'b1000, 3'd6, 3'd5, 3'd1);  // or R5,R1
    rom[2]     = enc(4'b0001, 3'd6, 3'd1, 3'd1);  // R1-R1 = 0
    rom[3]     = br(8'h20);
    rom[8'h20] = enc(4'b0001, 3'd6, 3'd1, 3'd2);  // 5-3 != 0
    rom[8'h21] = br(8'h30);
    rom[8'h22] = 16'hD000;                        // no-op
    rom[8'h23] = 16'hF000;
    run_prog(60, -1);
    total++; if (tr_a[2] !== 16'h8 || tr_b[2] !== 16'h2 || tr_sel[2] !== 4'h9) begin
      bad++; $display("FAIL regs_kept_r3r4 got=%h/%h/%h want=0008/0002/9", tr_a[2], tr_b[2], tr_sel[2]); end
    total++; if (tr_a[5] !== 16'hF || tr_b[5] !== 16'h5) begin
      bad++; $display("FAIL regs_kept_r5r1 got=%h/%h want=000f/0005", tr_a[5], tr_b[5]); end
    total++; if (first_seen(8'h20) !== 11) begin bad++; $display("FAIL branch_taken got=%0d want=11", first_seen(8'h20)); end
    total++; if (first_seen(8'h22) !== 16) begin bad++; $display("FAIL branch_not_taken got=%0d want=16", first_seen(8'h22)); end
    total++; if (first_seen(8'h30) !== -1) begin bad++; $display("FAIL branch_wrong_target got=%0d want=-1", first_seen(8'h30)); end
    total++; if (done_cyc !== 20) begin bad++; $display("FAIL branch_prog_done got=%0d want=20", done_cyc); end
  endtask

  task automatic test_midop_reset();
    logic seen;
    clear_rom();
    store_wait = 1000;
    rom[0] = enc(4'b0100, 3'd0, 3'd7, 3'd2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      seen = bus.mem_req;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL midop_req_seen got=%b want=1", seen); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL midop_req_async_drop got=%b want=0", bus.mem_req); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midop_busy got=%b want=0", bus.busy); end
    total++; if (bus.alu_a !== 16'h0 || bus.alu_sel !== 4'hD) begin
      bad++; $display("FAIL midop_alu_regs got=%h/%h want=0000/d", bus.alu_a, bus.alu_sel); end
    total++; if (bus.mem_addr !== 8'h0 || bus.mem_wdata !== 16'h0) begin
      bad++; $display("FAIL midop_mem_regs got=%h/%h want=00/0000", bus.mem_addr, bus.mem_wdata); end
    @(negedge clk);
    rst = 1'b1;
    store_wait = 0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0 || bus.instr_addr !== 8'h0) begin
      bad++; $display("FAIL midop_idle got=%b/%h want=0/00", bus.busy, bus.instr_addr); end
  endtask

  task automatic test_after_reset();
    clear_rom();
    rom[0] = enc(4'b1001, 3'd6, 3'd3, 3'd4);
    rom[1] = 16'hF000;
    run_prog(30, -1);
    total++; if (tr_a[2] !== 16'h0 || tr_b[2] !== 16'h0 || tr_sel[2] !== 4'h9) begin
      bad++; $display("FAIL regs_cleared got=%h/%h/%h want=0000/0000/9", tr_a[2], tr_b[2], tr_sel[2]); end
    total++; if (done_cyc !== 5) begin bad++; $display("FAIL post_reset_done got=%0d want=5", done_cyc); end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    load_wait  = 0;
    store_wait = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 16'h0000;
    clear_rom();
    test_reset();
    test_alu_ops();
    test_mem_handshake();
    test_branch();
    test_midop_reset();
    test_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
